// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: one shared sample-rate divider, per-channel saturating run counters and edge strobes.
// Optional two-flop input synchronizer enabled by defining MULTI_DEBOUNCER_SYNC_EN.
module multi_debouncer #(
  parameter int WIDTH           = 1,
  parameter int SAMPLE_CNT_MAX  = 25000,
  parameter int PRESS_CNT_MAX   = 150,
  parameter int RELEASE_CNT_MAX = 150
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int SC_W   = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int TH_MAX = (PRESS_CNT_MAX > RELEASE_CNT_MAX) ? PRESS_CNT_MAX : RELEASE_CNT_MAX;
  localparam int CH_W   = $clog2(TH_MAX + 1);

  localparam logic [SC_W-1:0] SAMPLE_LAST = SC_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [CH_W-1:0] PRESS_TH    = CH_W'(PRESS_CNT_MAX);
  localparam logic [CH_W-1:0] RELEASE_TH  = CH_W'(RELEASE_CNT_MAX);

  logic [SC_W-1:0]  sample_cnt_q;
  logic [SC_W-1:0]  sample_cnt_d;
  logic             tick;
  logic [WIDTH-1:0] sampled;

  assign tick = (sample_cnt_q == SAMPLE_LAST);

  always_comb begin
    sample_cnt_d = sample_cnt_q + SC_W'(1);
    if (tick) begin
      sample_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
    end
  end

`ifdef MULTI_DEBOUNCER_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= glitchy_signal;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = glitchy_signal;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CH_W-1:0] cnt_q;
      logic [CH_W-1:0] cnt_d;
      logic [CH_W-1:0] cnt_inc;
      logic [CH_W-1:0] th;
      logic            level_q;
      logic            level_d;
      logic            prev_q;

      // cnt_q always stays below th, so cnt_inc cannot overflow CH_W bits.
      always_comb begin
        th      = level_q ? RELEASE_TH : PRESS_TH;
        cnt_inc = cnt_q + CH_W'(1);
        cnt_d   = cnt_q;
        level_d = level_q;
        if (tick) begin
          if (sampled[gi] == level_q) begin
            cnt_d = '0;
          end else if (cnt_inc >= th) begin
            cnt_d   = '0;
            level_d = ~level_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q   <= '0;
          level_q <= 1'b0;
          prev_q  <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
          prev_q  <= level_q;
        end
      end

      assign debounced_signal[gi] = level_q;
      assign rise_pulse[gi]       = level_q & ~prev_q;
      assign fall_pulse[gi]       = ~level_q & prev_q;
    end
  endgenerate

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1: number of independent input channels.
REQ-002 The module SHALL have parameter SAMPLE_CNT_MAX, default 25000: clock cycles per sample period.
REQ-003 The module SHALL have parameter PRESS_CNT_MAX, default 150: consecutive high samples required to raise an output.
REQ-004 The module SHALL have parameter RELEASE_CNT_MAX, default 150: consecutive low samples required to lower an output.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port glitchy_signal, input, WIDTH bits: raw bouncing inputs.
REQ-008 The module SHALL have port debounced_signal, output, WIDTH bits: filtered level per channel.
REQ-009 The module SHALL have port rise_pulse, output, WIDTH bits: one-cycle strobe on each 0->1 change of debounced_signal.
REQ-010 The module SHALL have port fall_pulse, output, WIDTH bits: one-cycle strobe on each 1->0 change of debounced_signal.

Function
REQ-011 The module SHALL have one sample counter shared by all channels, counting 0..SAMPLE_CNT_MAX-1 and wrapping to 0.
REQ-012 The sample tick SHALL be asserted in the cycle in which the sample counter equals SAMPLE_CNT_MAX-1.
REQ-013 Each channel SHALL hold a saturating counter sized for the larger of PRESS_CNT_MAX and RELEASE_CNT_MAX.
REQ-014 Off a sample tick, every channel counter and every output level SHALL hold.
REQ-015 On a sample tick, if the sampled input equals the channel's debounced_signal bit, the channel counter SHALL clear to 0.
REQ-016 On a sample tick, if the sampled input differs from the channel's debounced_signal bit, the channel counter SHALL increment.
REQ-017 The applicable threshold SHALL be PRESS_CNT_MAX while debounced_signal is 0 and RELEASE_CNT_MAX while it is 1.
REQ-018 When the incremented count reaches the applicable threshold, debounced_signal SHALL toggle at the next clock edge and the channel counter SHALL clear to 0.
REQ-019 The counter SHALL never exceed the applicable threshold.
REQ-020 Any sample agreeing with the current output SHALL restart the count, so only uninterrupted runs of differing samples cause a toggle.
REQ-021 rise_pulse[i] SHALL be high for exactly one cycle: the first cycle in which debounced_signal[i] reads 1 after having been 0.
REQ-022 fall_pulse[i] SHALL be high for exactly one cycle: the first cycle in which debounced_signal[i] reads 0 after having been 1.
REQ-023 rise_pulse[i] and fall_pulse[i] SHALL never be high in the same cycle.
REQ-024 All channels SHALL be independent of each other.
REQ-025 Channels that reach their thresholds on the same tick SHALL toggle in the same cycle.
REQ-026 The module SHALL support PRESS_CNT_MAX >= 1, RELEASE_CNT_MAX >= 1 and SAMPLE_CNT_MAX >= 2.
REQ-027 With a value of 1, the corresponding threshold SHALL toggle the output on the first differing sample.

Reset
REQ-028 While rst_n is 0, debounced_signal, rise_pulse and fall_pulse SHALL be 0 immediately, without waiting for a clock edge.
REQ-029 While rst_n is 0, the sample counter, all channel counters and all synchronizer flops SHALL be 0.
REQ-030 A reset asserted mid-count SHALL discard the partial count.
REQ-031 After rst_n deasserts, the first sample tick SHALL occur SAMPLE_CNT_MAX cycles later.

Configuration
REQ-032 When macro MULTI_DEBOUNCER_SYNC_EN is defined, each glitchy_signal bit SHALL pass through a two-flop synchronizer before sampling, adding 2 cycles of latency.
REQ-033 When MULTI_DEBOUNCER_SYNC_EN is undefined, glitchy_signal SHALL be sampled directly, the synchronizer SHALL be absent, and there SHALL be no added latency.

Verification (WIDTH=2, SAMPLE_CNT_MAX=10, PRESS_CNT_MAX=4, RELEASE_CNT_MAX=2)
REQ-034 The bench SHALL toggle channel 0 every cycle for 10 cycles, hold it high for 30 cycles, then hold it low for 50 cycles, and SHALL check that debounced_signal[0] and rise_pulse[0] stay 0 throughout.
REQ-035 The bench SHALL toggle channel 0 for 10 cycles and then hold it high for 50 cycles, and SHALL check that debounced_signal[0] is 1 by cycle 50 (52 with sync), that rise_pulse[0] is high for exactly 1 cycle, and that channel 1 stays 0.
REQ-036 From a high output, the bench SHALL drive channel 0 low for 10 cycles and then high again, and SHALL check that there is no fall; it SHALL then hold channel 0 low for 30 cycles and check that debounced_signal[0] is 0 and fall_pulse[0] is high for exactly 1 cycle.
REQ-037 The bench SHALL drive both channels high together for 50 cycles and SHALL check that both rise in the same cycle, with rise_pulse equal to 2'b11 for exactly one cycle.
REQ-038 The bench SHALL hold channel 0 high for 30 cycles, assert rst_n low between clock edges, release rst_n, and keep channel 0 high; it SHALL check that all outputs are 0 immediately on reset and that the rise occurs 4 full sample periods after release, not earlier.
